// File: rtl/bar_height_feeder_if.sv
// Update-event handshake plus visualizer row-height write port.
// slave  : the feeder (consumes events, drives the BRAM write port)
// master : the processor side / observer (produces events, sees the writes)
interface bar_height_feeder_if #(
   parameter int SCREEN_HEIGHT = 42
) ();
   localparam int AW = $clog2(SCREEN_HEIGHT);

   logic          valid_in;
   logic [AW-1:0] addr_in;
   logic [31:0]   value_in;
   logic          ready_out;
   logic          tg_write_en;
   logic [AW-1:0] tg_addr;
   logic [31:0]   tg_input;

   modport slave (
      input  valid_in, addr_in, value_in,
      output ready_out, tg_write_en, tg_addr, tg_input
   );

   modport master (
      output valid_in, addr_in, value_in,
      input  ready_out, tg_write_en, tg_addr, tg_input
   );
endinterface

// File: rtl/bar_height_feeder.sv
// bar_height_feeder: buffers (row, value) updates in a small FIFO, converts
// each value to a clamped bar height and writes it to the visualizer BRAM
// only when it differs from the height already stored for that row.
// After reset or clear_in every row is swept to zero first.
// Optional macro BAR_LOG_SCALE_EN: height = MSB index + 1 instead of value >> SHIFT.
module bar_height_feeder #(
   parameter int SCREEN_WIDTH  = 76,
   parameter int SCREEN_HEIGHT = 42,
   parameter int FIFO_DEPTH    = 8,
   parameter int SHIFT         = 0
) (
   input  logic               proc_clk_in,
   input  logic               rst_in,
   input  logic               clear_in,
   input  logic               freeze_in,
   bar_height_feeder_if.slave bus,
   output logic               busy_out,
   output logic [15:0]        drop_count_out
);
   localparam int AW = $clog2(SCREEN_HEIGHT);
   localparam int HW = $clog2(SCREEN_WIDTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_sweep, w_sweep_nxt;
   logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [31:0]   r_fifo_val  [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;
   logic [HW-1:0] r_shadow [SCREEN_HEIGHT];
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [HW-1:0] r_height;
   logic [15:0]   r_drop;

   logic          w_full, w_empty, w_ready, w_accept, w_in_range;
   logic          w_push, w_pop, w_sweep_last, w_changed;
   logic [AW-1:0] w_head_addr;
   logic [HW-1:0] w_height;

   // Raw value to bar height in cells, clamped to the screen width.
   function automatic logic [HW-1:0] f_height(input logic [31:0] v);
      logic [31:0] h;
`ifdef BAR_LOG_SCALE_EN
      h = 32'd0;
      for (int i = 0; i < 32; i++) begin
         h = v[i] ? 32'(i + 1) : h;
      end
`else
      h = v >> SHIFT;
`endif
      h = (h > 32'(SCREEN_WIDTH)) ? 32'(SCREEN_WIDTH) : h;
      return h[HW-1:0];
   endfunction

   assign w_full       = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_empty      = (r_count == {(PW+1){1'b0}});
   assign w_sweep_last = (r_sweep == AW'(SCREEN_HEIGHT - 1));
   assign w_ready      = (r_state == ST_RUN) && !w_full && !clear_in;
   assign w_accept     = bus.valid_in && w_ready;
   assign w_in_range   = (32'(bus.addr_in) < 32'(SCREEN_HEIGHT));
   assign w_push       = w_accept && w_in_range;
   assign w_pop        = (r_state == ST_RUN) && !w_empty && !freeze_in && !clear_in;
   assign w_head_addr  = r_fifo_addr[r_rd_ptr];
   assign w_height     = f_height(r_fifo_val[r_rd_ptr]);
   assign w_changed    = (w_height != r_shadow[w_head_addr]);

   assign bus.ready_out = w_ready;
   assign busy_out      = (r_state == ST_CLEAR) || !w_empty;
   assign drop_count_out = r_drop;

   // State and sweep index register.
   always_ff @(posedge proc_clk_in) begin
      if (rst_in) begin
         r_state <= ST_CLEAR;
         r_sweep <= {AW{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_sweep <= w_sweep_nxt;
      end
   end

   // Next-state logic: clear_in restarts the sweep from any state.
   always_comb begin
      w_state_nxt = r_state;
      w_sweep_nxt = r_sweep;
      if (clear_in) begin
         w_state_nxt = ST_CLEAR;
         w_sweep_nxt = {AW{1'b0}};
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (w_sweep_last) begin
                  w_state_nxt = ST_RUN;
                  w_sweep_nxt = {AW{1'b0}};
               end else begin
                  w_state_nxt = ST_CLEAR;
                  w_sweep_nxt = r_sweep + AW'(1);
               end
            end
            ST_RUN: begin
               w_state_nxt = ST_RUN;
               w_sweep_nxt = {AW{1'b0}};
            end
            default: begin
               w_state_nxt = ST_CLEAR;
               w_sweep_nxt = {AW{1'b0}};
            end
         endcase
      end
   end

   // FIFO storage; no reset needed, occupancy is tracked separately.
   always_ff @(posedge proc_clk_in) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= bus.addr_in;
         r_fifo_val[r_wr_ptr]  <= bus.value_in;
      end
   end

   // FIFO pointers and occupancy; clear_in flushes.
   always_ff @(posedge proc_clk_in) begin
      if (rst_in || clear_in) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {(PW+1){1'b0}};
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Shadow copy of the heights currently held in the visualizer BRAM.
   always_ff @(posedge proc_clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < SCREEN_HEIGHT; i++) r_shadow[i] <= {HW{1'b0}};
      end else if (r_state == ST_CLEAR) begin
         r_shadow[r_sweep] <= {HW{1'b0}};
      end else if (w_pop && w_changed) begin
         r_shadow[w_head_addr] <= w_height;
      end
   end

   // Write stage: register a write only when the popped height is new.
   always_ff @(posedge proc_clk_in) begin
      if (rst_in) begin
         r_we     <= 1'b0;
         r_addr   <= {AW{1'b0}};
         r_height <= {HW{1'b0}};
      end else if (r_state == ST_CLEAR) begin
         r_we     <= 1'b0;
         r_addr   <= r_sweep;
         r_height <= {HW{1'b0}};
      end else if (w_pop && w_changed) begin
         r_we     <= 1'b1;
         r_addr   <= w_head_addr;
         r_height <= w_height;
      end else begin
         r_we     <= 1'b0;
      end
   end

   // Rejected out-of-range event counter, saturating.
   always_ff @(posedge proc_clk_in) begin
      if (rst_in) begin
         r_drop <= 16'd0;
      end else if (w_accept && !w_in_range && (r_drop != 16'hFFFF)) begin
         r_drop <= r_drop + 16'd1;
      end
   end

   // BRAM port: the sweep drives it directly, otherwise the write stage.
   always_comb begin
      if (r_state == ST_CLEAR) begin
         bus.tg_write_en = 1'b1;
         bus.tg_addr     = r_sweep;
         bus.tg_input    = 32'd0;
      end else begin
         bus.tg_write_en = r_we;
         bus.tg_addr     = r_addr;
         bus.tg_input    = {{(32-HW){1'b0}}, r_height};
      end
   end
endmodule

// File: tb/tb_bar_height_feeder.sv
// Self-checking bench for bar_height_feeder: a queue-based model checked on
// every cycle, plus directed scenarios with hand-computed write logs.
module tb_bar_height_feeder;
   localparam int SW = 76;
   localparam int SH = 42;
   localparam int FD = 8;
   localparam int SHIFT = 0;
`ifdef BAR_LOG_SCALE_EN
   localparam int unsigned EXP_TOPBIT = 32;
`else
   localparam int unsigned EXP_TOPBIT = 76;
`endif

   logic        clk = 1'b0;
   logic        rst_in, clear_in, freeze_in, busy_out;
   logic [15:0] drop_count_out;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   bar_height_feeder_if #(.SCREEN_HEIGHT(SH)) bus ();

   bar_height_feeder #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .FIFO_DEPTH(FD), .SHIFT(SHIFT)) dut (
      .proc_clk_in    (clk),
      .rst_in         (rst_in),
      .clear_in       (clear_in),
      .freeze_in      (freeze_in),
      .bus            (bus),
      .busy_out       (busy_out),
      .drop_count_out (drop_count_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // model state
   bit          m_ok = 1'b0;
   bit          m_clear, m_we;
   int          m_sweep;
   int unsigned m_addr, m_in, m_drop;
   int unsigned m_qa[$];
   logic [31:0] m_qv[$];
   int unsigned m_shadow[SH];
   // observed writes
   int unsigned log_a[$], log_v[$];
   int          log_c[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int unsigned mdl_h(input logic [31:0] v);
      longint unsigned h;
`ifdef BAR_LOG_SCALE_EN
      h = longint'($clog2(64'(v) + 64'd1));
`else
      h = 64'(v) >> SHIFT;
`endif
      return (h > 64'(SW)) ? SW : int'(h);
   endfunction

   // Compare DUT to model, log writes, then advance the model by one cycle.
   initial forever begin
      bit rdy, acc;
      int unsigned a, h;
      @(negedge clk);
      rdy = !m_clear && (m_qa.size() < FD) && !clear_in;
      if (m_ok && !rst_in) begin
         chk("tg_write_en", bus.tg_write_en, m_clear ? 1 : m_we);
         chk("tg_addr", bus.tg_addr, m_clear ? m_sweep : m_addr);
         chk("tg_input", bus.tg_input, m_clear ? 0 : m_in);
         chk("ready_out", bus.ready_out, rdy);
         chk("busy_out", busy_out, m_clear || (m_qa.size() > 0));
         chk("drop_count_out", drop_count_out, m_drop);
         if (bus.tg_write_en === 1'b1) begin
            log_a.push_back(bus.tg_addr);
            log_v.push_back(bus.tg_input);
            log_c.push_back(cyc);
         end
      end
      if (rst_in) begin
         m_ok = 1'b1; m_clear = 1'b1; m_sweep = 0; m_we = 1'b0;
         m_addr = 0; m_in = 0; m_drop = 0;
         m_qa.delete(); m_qv.delete();
         foreach (m_shadow[i]) m_shadow[i] = 0;
      end else if (m_ok) begin
         acc = bus.valid_in && rdy;
         if (clear_in) begin
            if (m_clear) begin
               m_shadow[m_sweep] = 0; m_addr = m_sweep; m_in = 0;
            end
            m_we = 1'b0; m_clear = 1'b1; m_sweep = 0;
            m_qa.delete(); m_qv.delete();
         end else if (m_clear) begin
            m_shadow[m_sweep] = 0; m_addr = m_sweep; m_in = 0; m_we = 1'b0;
            if (m_sweep == SH - 1) m_clear = 1'b0;
            else m_sweep++;
         end else begin
            m_we = 1'b0;
            if (m_qa.size() > 0 && !freeze_in) begin
               a = m_qa.pop_front();
               h = mdl_h(m_qv.pop_front());
               if (h != m_shadow[a]) begin
                  m_we = 1'b1; m_addr = a; m_in = h; m_shadow[a] = h;
               end
            end
            if (acc) begin
               if (bus.addr_in < SH) begin
                  m_qa.push_back(bus.addr_in);
                  m_qv.push_back(bus.value_in);
               end else if (m_drop < 65535) begin
                  m_drop++;
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one event and wait (bounded) for it to be accepted.
   task automatic push(input int a, input logic [31:0] v, output int acc_cyc);
      acc_cyc = -1;
      bus.valid_in = 1'b1;
      bus.addr_in  = 6'(a);
      bus.value_in = v;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.ready_out === 1'b1) acc_cyc = cyc;
         @(posedge clk);
         #1;
         if (acc_cyc >= 0) break;
      end
      bus.valid_in = 1'b0;
      chk("push accepted", acc_cyc >= 0, 1);
   endtask

   task automatic clear_log();
      log_a.delete(); log_v.delete(); log_c.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rst_in = 1'b1; clear_in = 1'b0; freeze_in = 1'b0;
      bus.valid_in = 1'b0; bus.addr_in = 6'd0; bus.value_in = 32'd0;
      @(posedge clk); @(posedge clk); #1;
      rst_in = 1'b0;
      clear_log();

      // 1: reset sweep of 42 zero writes, then idle and ready
      idle(45);
      chk("sweep count", log_a.size(), 42);
      for (int i = 0; i < 42 && i < log_a.size(); i++) begin
         chk("sweep addr", log_a[i], i);
         chk("sweep data", log_v[i], 0);
         chk("sweep consecutive", log_c[i] - log_c[0], i);
      end
      chk("ready after sweep", bus.ready_out, 1);
      chk("busy after sweep", busy_out, 0);

      // 2: latency N+2, skip unchanged height, write on change
      clear_log();
      push(5, 32'd10, c);
      idle(3);
      chk("t2 writes", log_a.size(), 1);
      if (log_a.size() >= 1) begin
         chk("t2 addr", log_a[0], 5);
         chk("t2 data", log_v[0], 10);
         chk("t2 latency", log_c[0] - c, 2);
      end
      push(5, 32'd10, c);
      idle(3);
      chk("t2 no rewrite", log_a.size(), 1);
      push(5, 32'd11, c);
      idle(3);
      chk("t2 writes after 11", log_a.size(), 2);
      if (log_a.size() >= 2) chk("t2 data 11", log_v[1], 11);

      // 3: clamp and top-bit value
      clear_log();
      push(3, 32'd1000, c);
      push(4, 32'h8000_0000, c);
      idle(4);
      chk("t3 writes", log_a.size(), 2);
      if (log_a.size() >= 2) begin
         chk("t3 clamp addr", log_a[0], 3);
         chk("t3 clamp data", log_v[0], 76);
         chk("t3 top addr", log_a[1], 4);
         chk("t3 top data", log_v[1], EXP_TOPBIT);
      end

      // 4: out-of-range rows are dropped and counted
      clear_log();
      push(42, 32'd7, c);
      push(63, 32'd7, c);
      idle(3);
      chk("t4 no writes", log_a.size(), 0);
      chk("t4 drop count", drop_count_out, 2);
      chk("t4 ready", bus.ready_out, 1);

      // 5: freeze fills the FIFO, release drains in order
      clear_log();
      freeze_in = 1'b1;
      for (int i = 0; i < 8; i++) push(10 + i, 32'(i + 1), c);
      bus.valid_in = 1'b1; bus.addr_in = 6'd18; bus.value_in = 32'd9;
      @(negedge clk);
      chk("t5 ready when full", bus.ready_out, 0);
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      chk("t5 no writes frozen", log_a.size(), 0);
      freeze_in = 1'b0;
      idle(12);
      chk("t5 writes", log_a.size(), 8);
      for (int i = 0; i < 8 && i < log_a.size(); i++) begin
         chk("t5 addr", log_a[i], 10 + i);
         chk("t5 data", log_v[i], i + 1);
         chk("t5 back-to-back", log_c[i] - log_c[0], i);
      end

      // 6: clear flushes queued entries; clear mid-sweep restarts at row 0
      freeze_in = 1'b1;
      for (int i = 0; i < 5; i++) push(20 + i, 32'(30 + i), c);
      clear_log();
      clear_in = 1'b1; idle(1); clear_in = 1'b0;
      idle(20);
      clear_in = 1'b1; idle(1); clear_in = 1'b0;
      idle(45);
      freeze_in = 1'b0;
      idle(5);
      chk("t6 writes", log_a.size(), 63);
      for (int i = 0; i < 63 && i < log_a.size(); i++) begin
         chk("t6 addr", log_a[i], (i < 21) ? i : i - 21);
         chk("t6 data", log_v[i], 0);
      end
      chk("t6 busy", busy_out, 0);
      chk("t6 drop kept", drop_count_out, 2);

      // 7: reset mid-stream discards the queue and re-sweeps
      freeze_in = 1'b1;
      push(30, 32'd5, c);
      push(31, 32'd6, c);
      rst_in = 1'b1; idle(1); rst_in = 1'b0;
      freeze_in = 1'b0;
      clear_log();
      idle(46);
      chk("t7 writes", log_a.size(), 42);
      chk("t7 drop reset", drop_count_out, 0);
      chk("t7 busy", busy_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bar_height_feeder.md
Name: bar_height_feeder

Overview:
- Sits directly upstream of the bar-graph visualizer and drives its row-height BRAM write port (tg_write_en / tg_addr / tg_input).
- Accepts (row, raw value) update events from the processor side through a valid/ready handshake and buffers them in a small FIFO.
- Scales and clamps each value to a bar height in character cells, skips writes that would not change the stored height, and sweeps all rows to zero after reset or on a clear command.

Parameters:
- SCREEN_WIDTH, 76, maximum bar height in cells; the clamp ceiling.
- SCREEN_HEIGHT, 42, number of rows (bars); legal row addresses are 0..SCREEN_HEIGHT-1.
- FIFO_DEPTH, 8, number of update-FIFO entries; must be a power of two, minimum 2.
- SHIFT, 0, right-shift applied to the raw value before the clamp (linear mode).

Ports:
- proc_clk_in  input  1  processor-domain clock; the same clock that drives the visualizer write port.
- rst_in  input  1  synchronous reset, active-high.
- clear_in  input  1  single-cycle pulse; flushes the FIFO and re-zeroes all rows.
- freeze_in  input  1  while high, no FIFO pops occur; input is still accepted until the FIFO is full.
- valid_in  input  1  an update event is presented.
- addr_in  input  $clog2(SCREEN_HEIGHT)  target row.
- value_in  input  32  raw, unsigned value.
- ready_out  output  1  event is accepted on a cycle where valid_in && ready_out.
- tg_write_en  output  1  write strobe to the visualizer BRAM.
- tg_addr  output  $clog2(SCREEN_HEIGHT)  write row.
- tg_input  output  32  bar height, zero-extended.
- busy_out  output  1  high while in CLEAR or while the FIFO is non-empty.
- drop_count_out  output  16  count of rejected out-of-range events; saturates at 0xFFFF.

Behaviour:

Reset:
- Reset is synchronous and active-high (rst_in).
- Reset values: tg_write_en=0, tg_addr=0, tg_input=0, drop_count_out=0, FIFO empty, shadow heights all 0.
- The FSM enters CLEAR with sweep index 0. ready_out=0 and busy_out=1 in the first cycle after reset.

FSM states:
- CLEAR:
  - Each cycle, drive tg_write_en=1, tg_addr=sweep index, tg_input=0. Zero that row's shadow entry and increment the index.
  - After the write to row SCREEN_HEIGHT-1, go to RUN. This takes exactly SCREEN_HEIGHT cycles.
  - ready_out=0 throughout CLEAR.
- RUN:
  - ready_out = !fifo_full.
  - If the FIFO is non-empty and freeze_in=0, pop one entry per cycle.
  - A popped entry goes through a single registered stage that computes the height and compares it with the shadow entry.

Timing:
- Event accepted in cycle N → earliest pop in cycle N+1 (no fall-through) → tg_write_en high in cycle N+2.
- Sustained throughput is one write per cycle.

Height arithmetic:
- h = value_in >> SHIFT, computed at full 32-bit width.
- If h > SCREEN_WIDTH, then h = SCREEN_WIDTH.
- If h equals shadow[addr], no write is issued (tg_write_en=0 that cycle).
- Otherwise the write is issued and shadow[addr] is updated in the same cycle.

Out-of-range addresses:
- An event with addr_in >= SCREEN_HEIGHT is still handshaken (ready_out applies) but is not enqueued.
- drop_count_out increments by 1, saturating.

Outputs between writes:
- tg_write_en is low whenever no write is issued.
- tg_addr and tg_input hold their last values.

clear_in:
- Any state: flush the FIFO, discard the in-flight stage, reset the sweep index to 0, enter CLEAR on the next cycle.
- clear_in during CLEAR restarts the sweep from row 0.
- drop_count_out is not cleared by clear_in.

Simultaneous events:
- clear_in together with valid_in: the event is not accepted (ready_out is forced 0 that cycle).
- Push and pop in the same cycle: FIFO occupancy is unchanged.
- Push while full: impossible, because ready_out=0.

freeze_in:
- Does not stall CLEAR.
- An entry already in the stage register completes its write.

Reset mid-sweep or mid-stream: behaves exactly as reset from idle.

Optional Feature:
- Macro: BAR_LOG_SCALE_EN.
- When defined: h = 0 if value_in == 0, else (index of the most-significant set bit + 1), range 1..32. SHIFT is ignored. The clamp to SCREEN_WIDTH still applies.
- When undefined: linear mode (shift then clamp) as described above.
- All other behaviour is identical in both builds.

Test Plan:
1. Assert rst_in for 1 cycle → 42 consecutive cycles of tg_write_en=1 with tg_addr 0..41 and tg_input=0; then ready_out=1 and busy_out=0.
2. After CLEAR, push (addr 5, value 10) in cycle N, SHIFT=0 → tg_write_en=1, tg_addr=5, tg_input=10 in cycle N+2. Push (5, 10) again → no write. Push (5, 11) → write of 11.
3. Push (3, 1000) → tg_input=76 (clamped). Push (4, 0x80000000) with BAR_LOG_SCALE_EN defined → tg_input=32.
4. Push (42, 7) and then (63, 7) → no tg_write_en, drop_count_out=2, ready_out stays 1.
5. Hold freeze_in=1 and push 9 events with distinct rows → ready_out falls after the 8th accept. Release freeze_in → 8 back-to-back writes in FIFO order.
6. With 5 entries queued and frozen, pulse clear_in → FIFO flushed and a 42-cycle zero sweep follows. Pulse clear_in again at sweep row 20 → sweep restarts at row 0. No queued entry is ever written.
